// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INCR = 32'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous show-ahead FIFO; head is registered, so a push into an empty
// FIFO becomes visible the following cycle. Flush wins over push and pop.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !(rst || flush)) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Fetch front end: one outstanding request to a variable-latency memory,
// words buffered in a show-ahead FIFO; redirect flushes and restarts fetch.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e   state_q, state_d;
  logic [31:0]    fetch_pc_q, fetch_pc_d;
  logic [31:0]    req_addr_q, req_addr_d;
  logic [31:0]    rpc;
  logic [CW-1:0]  count;
  logic           full, empty;
  logic           push, pop, flush;
  logic           room_after;
  fetch_entry_t   head, push_ent;

  assign rpc  = align_word(redirect_pc);
  assign pop  = instr_valid & instr_ready;
  // A same-cycle pop always leaves room; otherwise the push must not fill the FIFO.
  assign room_after = pop || (int'(count) < DEPTH - 1);
  assign push_ent = '{pc: req_addr_q, instr: mem_rdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          fetch_pc_d = rpc;
          req_addr_d = rpc;
          state_d    = WAIT;
        end else if (!full) begin
          req_addr_d = fetch_pc_q;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          fetch_pc_d = rpc;
          if (mem_ack) begin
            req_addr_d = rpc;
            state_d    = WAIT;
          end else begin
            state_d    = DISCARD;
          end
        end else if (mem_ack) begin
          fetch_pc_d = fetch_pc_q + PC_INCR;
          if (room_after) req_addr_d = fetch_pc_q + PC_INCR;
          else            state_d    = IDLE;
        end
      end
      DISCARD: begin
        // The stale request stays on the bus until the memory retires it.
        if (redirect) fetch_pc_d = rpc;
        if (mem_ack) begin
          req_addr_d = redirect ? rpc : fetch_pc_q;
          state_d    = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req = (state_q == WAIT) || (state_q == DISCARD);
    push    = (state_q == WAIT) && mem_ack && !redirect;
    flush   = redirect;
  end

  assign mem_addr = req_addr_q;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .flush    (flush),
    .head_dat (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  assign instr_valid = ~empty;
  assign instr_out   = empty ? 32'd0 : head.instr;
  assign instr_pc    = empty ? 32'd0 : head.pc;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: vector table, directed redirect/latency sequences,
// and a randomized run against an in-order PC stream model.
module tb_fetch_prefetch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, mem_req, mem_ack, instr_valid, instr_ready, redirect;
  logic [31:0] mem_addr, mem_rdata, instr_out, instr_pc, redirect_pc;

  always #5 clk = ~clk;

  fetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cur_lat  = 1;
  int mem_cnt  = 0;
  bit rnd_lat  = 1'b0;

  typedef struct {
    bit          r;
    bit          rdy;
    bit          ck;
    bit          req;
    logic [31:0] addr;
    bit          v;
    logic [31:0] pc;
    logic [31:0] ins;
    bit          rv;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Memory model: acks after cur_lat cycles of mem_req, data = addr + 0x1000.
  task automatic drive(input bit r, input bit rdy, input bit redir, input logic [31:0] rpc);
    rst         = r;
    instr_ready = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    mem_ack     = 1'b0;
    mem_rdata   = 32'hDEAD_BEEF;
    if (r) begin
      mem_cnt = 0;
    end else if (mem_req === 1'b1) begin
      if (mem_cnt == 0 && rnd_lat) cur_lat = $urandom_range(1, 4);
      if (mem_cnt >= cur_lat - 1) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_addr + 32'h1000;
        mem_cnt   = 0;
      end else begin
        mem_cnt++;
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    tick;
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    tick;
  endtask

  function automatic void add(bit r, bit rdy, bit ck, bit req, logic [31:0] a,
                              bit v, logic [31:0] pc, logic [31:0] ins, bit rv);
    vec_t e;
    e.r = r; e.rdy = rdy; e.ck = ck; e.req = req; e.addr = a;
    e.v = v; e.pc = pc; e.ins = ins; e.rv = rv;
    tbl.push_back(e);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_pc, prev_addr, last_pc, rpc;
    bit          prev_req, prev_ack, exp_invalid, seen, rdy, redir;
    int          pops, last_pop, run_len;

    drive(1'b1, 1'b0, 1'b0, 32'd0);
    cur_lat = 1;

    // ---- table: 1-cycle memory, streaming, mid-WAIT reset, fill to full ----
    add(1, 1, 0, 0, 32'h0,  0, 32'h0, 32'h0,    0);
    add(1, 1, 0, 0, 32'h0,  0, 32'h0, 32'h0,    0);
    add(0, 1, 1, 0, 32'h0,  0, 32'h0, 32'h0,    1);
    add(0, 1, 1, 1, 32'h0,  0, 32'h0, 32'h0,    0);
    add(0, 1, 1, 1, 32'h4,  1, 32'h0, 32'h1000, 0);
    add(0, 1, 1, 1, 32'h8,  1, 32'h4, 32'h1004, 0);
    add(0, 1, 1, 1, 32'hC,  1, 32'h8, 32'h1008, 0);
    add(1, 1, 1, 1, 32'h10, 1, 32'hC, 32'h100C, 0);
    add(0, 0, 1, 0, 32'h0,  0, 32'h0, 32'h0,    1);
    add(0, 0, 1, 1, 32'h0,  0, 32'h0, 32'h0,    0);
    add(0, 0, 1, 1, 32'h4,  1, 32'h0, 32'h1000, 0);
    add(0, 0, 1, 1, 32'h8,  1, 32'h0, 32'h1000, 0);
    add(0, 0, 1, 1, 32'hC,  1, 32'h0, 32'h1000, 0);
    add(0, 1, 1, 0, 32'h0,  1, 32'h0, 32'h1000, 0);
    add(0, 0, 1, 0, 32'h0,  1, 32'h4, 32'h1004, 0);
    add(0, 0, 1, 1, 32'h10, 1, 32'h4, 32'h1004, 0);
    add(0, 0, 1, 0, 32'h0,  1, 32'h4, 32'h1004, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].ck) begin
        chk1($sformatf("T%0d_req", i), mem_req, tbl[i].req);
        if (tbl[i].req || tbl[i].rv) chk($sformatf("T%0d_addr", i), mem_addr, tbl[i].addr);
        chk1($sformatf("T%0d_valid", i), instr_valid, tbl[i].v);
        if (tbl[i].v || tbl[i].rv) begin
          chk($sformatf("T%0d_pc", i), instr_pc, tbl[i].pc);
          chk($sformatf("T%0d_instr", i), instr_out, tbl[i].ins);
        end
      end
      drive(tbl[i].r, tbl[i].rdy, 1'b0, 32'd0);
      tick;
    end

    // ---- 3-cycle memory: address held 3 cycles, one instruction per 3 cycles ----
    do_reset;
    cur_lat  = 3;
    pops     = 0;
    last_pop = -1;
    run_len  = 0;
    prev_req = 1'b0;
    prev_addr = 32'h0;
    for (int c = 0; c < 40; c++) begin
      if (mem_req && prev_req && mem_addr == prev_addr) begin
        run_len++;
      end else begin
        if (prev_req && run_len > 0) chk("L3_addr_hold", run_len, 3);
        run_len = mem_req ? 1 : 0;
      end
      if (instr_valid) begin
        chk($sformatf("L3_pc%0d", pops), instr_pc, 32'(pops * 4));
        chk($sformatf("L3_instr%0d", pops), instr_out, 32'(pops * 4) + 32'h1000);
        if (last_pop >= 0) chk("L3_gap", c - last_pop, 3);
        last_pop = c;
        pops++;
      end
      prev_req  = mem_req;
      prev_addr = mem_addr;
      drive(1'b0, 1'b1, 1'b0, 32'd0);
      tick;
    end
    chk1("L3_enough_pops", pops >= 11, 1'b1);

    // ---- redirect to 0x42 while the 0x8 request is outstanding ----
    do_reset;
    cur_lat = 3;
    seen    = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      if (mem_req && mem_addr == 32'h8) seen = 1'b1;
      else begin
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        tick;
      end
    end
    chk1("RD_req8_seen", seen, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    tick;
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0042);
    tick;
    chk1("RD_valid_after", instr_valid, 1'b0);
    chk1("RD_req_held", mem_req, 1'b1);
    chk("RD_addr_held", mem_addr, 32'h8);
    for (int c = 0; c < 20 && mem_addr == 32'h8; c++) begin
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      tick;
    end
    chk1("RD_next_req", mem_req, 1'b1);
    chk("RD_next_addr", mem_addr, 32'h40);
    for (int c = 0; c < 20 && !instr_valid; c++) begin
      drive(1'b0, 1'b1, 1'b0, 32'd0);
      tick;
    end
    chk1("RD_first_valid", instr_valid, 1'b1);
    chk("RD_first_pc", instr_pc, 32'h40);
    chk("RD_first_instr", instr_out, 32'h1040);

    // ---- redirect coinciding with mem_ack and a pop ----
    do_reset;
    cur_lat = 1;
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b1, 1'b0, 32'd0);
      tick;
    end
    chk1("RA_pre_req", mem_req, 1'b1);
    chk1("RA_pre_valid", instr_valid, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0203);
    tick;
    chk1("RA_valid_after", instr_valid, 1'b0);
    chk1("RA_req", mem_req, 1'b1);
    chk("RA_addr", mem_addr, 32'h200);
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    tick;
    chk1("RA_valid2", instr_valid, 1'b1);
    chk("RA_pc2", instr_pc, 32'h200);
    chk("RA_instr2", instr_out, 32'h1200);

    // ---- randomized run: popped stream must be consecutive PCs from last redirect ----
    do_reset;
    rnd_lat     = 1'b1;
    mem_cnt     = 0;
    exp_pc      = 32'h0;
    pops        = 0;
    prev_req    = 1'b0;
    prev_ack    = 1'b0;
    prev_addr   = 32'h0;
    exp_invalid = 1'b0;
    last_pc     = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      if (exp_invalid) chk1("RND_valid_after_redirect", instr_valid, 1'b0);
      if (prev_req && !prev_ack) begin
        chk1("RND_req_held", mem_req, 1'b1);
        chk("RND_addr_stable", mem_addr, prev_addr);
      end
      if (mem_req) chk("RND_addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 24) == 0);
      rpc   = ($urandom_range(0, 1) != 0) ? $urandom() : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
      if (!redir && instr_valid && rdy) begin
        chk("RND_pc", instr_pc, exp_pc);
        chk("RND_instr", instr_out, exp_pc + 32'h1000);
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (redir) exp_pc = {rpc[31:2], 2'b00};
      exp_invalid = redir;
      drive(1'b0, rdy, redir, rpc);
      prev_req  = mem_req;
      prev_addr = mem_addr;
      prev_ack  = mem_ack;
      tick;
    end
    chk1("RND_liveness", pops > 300, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
